// File: rtl/load_store_unit.sv
// Load/store unit: accepts one memory instruction, performs a single bus word
// access with byte lanes, and returns sign/zero-extended load data.
module load_store_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 15
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_valid,
  input  logic                  i_memRead,
  input  logic                  i_memWrite,
  input  logic [2:0]            i_memFunct,
  input  logic [DATA_WIDTH-1:0] i_result,
  input  logic [DATA_WIDTH-1:0] i_dataB,
  output logic                  o_busReq,
  output logic                  o_busWrite,
  output logic [ADDR_WIDTH-1:0] o_busAddr,
  output logic [3:0]            o_busByteEnable,
  output logic [DATA_WIDTH-1:0] o_busWrData,
  input  logic                  i_busAck,
  input  logic [DATA_WIDTH-1:0] i_busRdData,
  output logic                  o_stall,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_readData,
  output logic                  o_misaligned,
  output logic                  o_accessFault
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [2:0]            r_funct3;
  logic                  r_write;
  logic                  r_misaligned;
  logic                  r_fault;
  logic [CNT_W-1:0]      r_wait_cnt;
  logic [DATA_WIDTH-1:0] r_read_data;

  logic                  w_accept;
  logic                  w_legal_f3;
  logic                  w_req_fault;
  logic                  w_req_misaligned;
  logic                  w_req_ok;
  logic [ADDR_WIDTH-1:0] w_req_addr;
  logic [CNT_W-1:0]      w_cnt_next;
  logic                  w_timeout;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [DATA_WIDTH-1:0] w_load_data;

  // Request classification happens on the raw inputs so the accept edge can
  // choose between ACCESS and DONE directly.
  assign w_accept   = (r_state == S_IDLE) && i_valid && (i_memRead || i_memWrite);
  assign w_req_addr = ADDR_WIDTH'(i_result);
  assign w_legal_f3 = (i_memFunct[1:0] != 2'b11) &&
                      !(i_memFunct[2] && (i_memFunct[1] || i_memWrite));
  assign w_req_fault      = (i_memRead && i_memWrite) || !w_legal_f3;
  assign w_req_misaligned = !w_req_fault &&
                            (((i_memFunct[1:0] == 2'b01) && w_req_addr[0]) ||
                             ((i_memFunct[1:0] == 2'b10) && (w_req_addr[1:0] != 2'b00)));
  assign w_req_ok         = !w_req_fault && !w_req_misaligned;

  assign w_cnt_next = r_wait_cnt + 1'b1;
  assign w_timeout  = (w_cnt_next == CNT_W'(TIMEOUT));

  assign w_byte = i_busRdData[{r_addr[1:0], 3'b000} +: 8];
  assign w_half = i_busRdData[{r_addr[1], 4'b0000} +: 16];

  always_comb begin
    w_load_data = i_busRdData;
    case (r_funct3)
      3'b000:  w_load_data = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
      3'b001:  w_load_data = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
      3'b100:  w_load_data = {{(DATA_WIDTH-8){1'b0}}, w_byte};
      3'b101:  w_load_data = {{(DATA_WIDTH-16){1'b0}}, w_half};
      default: w_load_data = i_busRdData;
    endcase
  end

  // NOTE: every state register uses <= so all flops update from pre-edge values.
  always_ff @(posedge i_clock) begin
    if (!i_reset) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  // NOTE: every output and next-state value gets a default first, so no path
  // through the case can leave a latch behind.
  always_comb begin
    w_state_next    = r_state;
    o_busReq        = 1'b0;
    o_busWrite      = 1'b0;
    o_busAddr       = '0;
    o_busByteEnable = 4'b0000;
    o_busWrData     = '0;
    o_done          = 1'b0;
    o_misaligned    = 1'b0;
    o_accessFault   = 1'b0;
    o_stall         = w_accept;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_next = w_req_ok ? S_ACCESS : S_DONE;
      end
      S_ACCESS: begin
        o_stall    = 1'b1;
        o_busReq   = 1'b1;
        o_busWrite = r_write;
        o_busAddr  = {r_addr[ADDR_WIDTH-1:2], 2'b00};
        case (r_funct3[1:0])
          2'b00: begin
            o_busByteEnable = 4'b0001 << r_addr[1:0];
            o_busWrData     = {(DATA_WIDTH/8){r_wdata[7:0]}};
          end
          2'b01: begin
            o_busByteEnable = 4'b0011 << {r_addr[1], 1'b0};
            o_busWrData     = {(DATA_WIDTH/16){r_wdata[15:0]}};
          end
          default: begin
            o_busByteEnable = 4'b1111;
            o_busWrData     = r_wdata;
          end
        endcase
        if (i_busAck || w_timeout) w_state_next = S_DONE;
      end
      S_DONE: begin
        o_done        = 1'b1;
        o_misaligned  = r_misaligned;
        o_accessFault = r_fault;
        w_state_next  = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Ack wins over the timeout when both land on the final wait cycle.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_addr       <= '0;
      r_wdata      <= '0;
      r_funct3     <= 3'b000;
      r_write      <= 1'b0;
      r_misaligned <= 1'b0;
      r_fault      <= 1'b0;
      r_wait_cnt   <= '0;
      r_read_data  <= '0;
    end else if (w_accept) begin
      r_addr       <= w_req_addr;
      r_wdata      <= i_dataB;
      r_funct3     <= i_memFunct;
      r_write      <= i_memWrite;
      r_misaligned <= w_req_misaligned;
      r_fault      <= w_req_fault;
      r_wait_cnt   <= '0;
    end else if (r_state == S_ACCESS) begin
      if (i_busAck) begin
        if (!r_write) r_read_data <= w_load_data;
      end else if (w_timeout) begin
        r_fault <= 1'b1;
      end else begin
        r_wait_cnt <= w_cnt_next;
      end
    end
  end

  assign o_readData = r_read_data;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: byte/half/word loads and stores,
// misalignment, illegal encodings, bus timeout and reset during an access.
module tb_load_store_unit;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic        i_valid;
  logic        i_memRead;
  logic        i_memWrite;
  logic [2:0]  i_memFunct;
  logic [31:0] i_result;
  logic [31:0] i_dataB;
  logic        o_busReq;
  logic        o_busWrite;
  logic [31:0] o_busAddr;
  logic [3:0]  o_busByteEnable;
  logic [31:0] o_busWrData;
  logic        i_busAck;
  logic [31:0] i_busRdData;
  logic        o_stall;
  logic        o_done;
  logic [31:0] o_readData;
  logic        o_misaligned;
  logic        o_accessFault;

  int n_cmp = 0;
  int n_bad = 0;

  load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(15)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid),
    .i_memRead(i_memRead), .i_memWrite(i_memWrite), .i_memFunct(i_memFunct),
    .i_result(i_result), .i_dataB(i_dataB),
    .o_busReq(o_busReq), .o_busWrite(o_busWrite), .o_busAddr(o_busAddr),
    .o_busByteEnable(o_busByteEnable), .o_busWrData(o_busWrData),
    .i_busAck(i_busAck), .i_busRdData(i_busRdData),
    .o_stall(o_stall), .o_done(o_done), .o_readData(o_readData),
    .o_misaligned(o_misaligned), .o_accessFault(o_accessFault)
  );

  always #5 i_clock = ~i_clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  // Present one request, confirm the accept-cycle stall, then drop the request.
  task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] data);
    i_valid = 1'b1; i_memRead = rd; i_memWrite = wr;
    i_memFunct = f3; i_result = addr; i_dataB = data;
    #1;
    check("stall_accept", {31'd0, o_stall}, 32'd1);
    tick();
    i_valid = 1'b0; i_memRead = 1'b0; i_memWrite = 1'b0;
    #1;
  endtask

  task automatic ack_now(input logic [31:0] rd_data);
    i_busAck = 1'b1; i_busRdData = rd_data;
    tick();
    i_busAck = 1'b0;
    #1;
  endtask

  initial begin
    i_reset = 1'b0; i_valid = 1'b0; i_memRead = 1'b0; i_memWrite = 1'b0;
    i_memFunct = 3'b000; i_result = '0; i_dataB = '0;
    i_busAck = 1'b0; i_busRdData = '0;
    repeat (3) tick();
    check("rst_busReq", {31'd0, o_busReq}, 32'd0);
    check("rst_done", {31'd0, o_done}, 32'd0);
    check("rst_readData", o_readData, 32'd0);
    check("rst_stall", {31'd0, o_stall}, 32'd0);
    i_reset = 1'b1;
    tick();

    // Valid without a memory op stays idle.
    i_valid = 1'b1; #1;
    check("novop_stall", {31'd0, o_stall}, 32'd0);
    tick();
    check("novop_busReq", {31'd0, o_busReq}, 32'd0);
    check("novop_done", {31'd0, o_done}, 32'd0);
    i_valid = 1'b0;

    // LB 0x103, ack in first access cycle.
    issue(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0);
    check("lb_busReq", {31'd0, o_busReq}, 32'd1);
    check("lb_be", {28'd0, o_busByteEnable}, 32'h8);
    check("lb_addr", o_busAddr, 32'h0000_0100);
    check("lb_write", {31'd0, o_busWrite}, 32'd0);
    check("lb_done_early", {31'd0, o_done}, 32'd0);
    ack_now(32'h80FF_1234);
    check("lb_done", {31'd0, o_done}, 32'd1);
    check("lb_data", o_readData, 32'hFFFF_FF80);
    check("lb_req_drop", {31'd0, o_busReq}, 32'd0);
    check("lb_stall_done", {31'd0, o_stall}, 32'd0);
    tick();
    check("lb_done_pulse", {31'd0, o_done}, 32'd0);

    // SH 0x202: half lanes, replicated data, read data untouched.
    issue(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h0000_ABCD);
    check("sh_be", {28'd0, o_busByteEnable}, 32'hC);
    check("sh_wdata", o_busWrData, 32'hABCD_ABCD);
    check("sh_addr", o_busAddr, 32'h0000_0200);
    check("sh_write", {31'd0, o_busWrite}, 32'd1);
    ack_now(32'h1234_5678);
    check("sh_done", {31'd0, o_done}, 32'd1);
    check("sh_readData", o_readData, 32'hFFFF_FF80);
    tick();

    // SB 0x001.
    issue(1'b0, 1'b1, 3'b000, 32'h0000_0001, 32'h1234_565A);
    check("sb_be", {28'd0, o_busByteEnable}, 32'h2);
    check("sb_wdata", o_busWrData, 32'h5A5A_5A5A);
    ack_now(32'h0);
    tick();

    // LBU 0x001 and LH 0x002.
    issue(1'b1, 1'b0, 3'b100, 32'h0000_0001, 32'h0);
    ack_now(32'h0000_A500);
    check("lbu_data", o_readData, 32'h0000_00A5);
    tick();
    issue(1'b1, 1'b0, 3'b001, 32'h0000_0002, 32'h0);
    check("lh_be", {28'd0, o_busByteEnable}, 32'hC);
    ack_now(32'h8001_7777);
    check("lh_data", o_readData, 32'hFFFF_8001);
    tick();

    // LW 0x101 misaligned; request held into DONE must not stall or be taken.
    i_valid = 1'b1; i_memRead = 1'b1; i_memFunct = 3'b010; i_result = 32'h101;
    #1;
    check("lw_mis_stall_acc", {31'd0, o_stall}, 32'd1);
    tick();
    check("lw_mis_flag", {31'd0, o_misaligned}, 32'd1);
    check("lw_mis_done", {31'd0, o_done}, 32'd1);
    check("lw_mis_busReq", {31'd0, o_busReq}, 32'd0);
    check("lw_mis_stall_done", {31'd0, o_stall}, 32'd0);
    check("lw_mis_fault", {31'd0, o_accessFault}, 32'd0);
    i_valid = 1'b0; i_memRead = 1'b0;
    tick();
    check("lw_mis_pulse", {31'd0, o_misaligned}, 32'd0);
    check("lw_mis_idle_req", {31'd0, o_busReq}, 32'd0);

    // Illegal encodings: load funct3 011, store funct3 100, read+write together.
    issue(1'b1, 1'b0, 3'b011, 32'h0000_0010, 32'h0);
    check("f3_011_fault", {31'd0, o_accessFault}, 32'd1);
    check("f3_011_busReq", {31'd0, o_busReq}, 32'd0);
    tick();
    issue(1'b0, 1'b1, 3'b100, 32'h0000_0010, 32'h0);
    check("sbu_fault", {31'd0, o_accessFault}, 32'd1);
    check("sbu_mis", {31'd0, o_misaligned}, 32'd0);
    tick();
    issue(1'b1, 1'b1, 3'b010, 32'h0000_0010, 32'h0);
    check("rw_fault", {31'd0, o_accessFault}, 32'd1);
    check("rw_done", {31'd0, o_done}, 32'd1);
    tick();
    check("fault_readData", o_readData, 32'hFFFF_8001);

    // LHU 0x40 with ack withheld: 15 request cycles, then fault.
    issue(1'b1, 1'b0, 3'b101, 32'h0000_0040, 32'h0);
    for (int k = 1; k <= 15; k++) begin
      check($sformatf("to_req_c%0d", k), {31'd0, o_busReq}, 32'd1);
      tick();
    end
    check("to_fault", {31'd0, o_accessFault}, 32'd1);
    check("to_busReq", {31'd0, o_busReq}, 32'd0);
    check("to_done", {31'd0, o_done}, 32'd1);
    check("to_readData", o_readData, 32'hFFFF_8001);
    tick();

    // LHU 0x42 with ack on the 15th cycle completes normally.
    issue(1'b1, 1'b0, 3'b101, 32'h0000_0042, 32'h0);
    repeat (14) tick();
    check("ack15_busReq", {31'd0, o_busReq}, 32'd1);
    ack_now(32'hBEEF_1234);
    check("ack15_done", {31'd0, o_done}, 32'd1);
    check("ack15_fault", {31'd0, o_accessFault}, 32'd0);
    check("ack15_data", o_readData, 32'h0000_BEEF);
    tick();

    // Reset during ACCESS, late ack ignored, then a clean LW.
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0);
    check("rstmid_busReq_pre", {31'd0, o_busReq}, 32'd1);
    i_reset = 1'b0;
    tick();
    check("rstmid_busReq", {31'd0, o_busReq}, 32'd0);
    check("rstmid_readData", o_readData, 32'd0);
    check("rstmid_stall", {31'd0, o_stall}, 32'd0);
    check("rstmid_be", {28'd0, o_busByteEnable}, 32'd0);
    i_reset = 1'b1;
    ack_now(32'h5555_5555);
    check("lateack_done", {31'd0, o_done}, 32'd0);
    check("lateack_busReq", {31'd0, o_busReq}, 32'd0);
    check("lateack_readData", o_readData, 32'd0);
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0104, 32'h0);
    check("lw_addr", o_busAddr, 32'h0000_0104);
    check("lw_be", {28'd0, o_busByteEnable}, 32'hF);
    ack_now(32'hDEAD_BEEF);
    check("lw_done", {31'd0, o_done}, 32'd1);
    check("lw_data", o_readData, 32'hDEAD_BEEF);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning data path and bus data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, meaning bus address width.
REQ-003 SHALL have parameter TIMEOUT, default 15, meaning maximum wait cycles for bus acknowledge.
REQ-004 SHALL have port i_clock input 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port i_reset input 1, reset; synchronous and active-low.
REQ-006 SHALL have port i_valid input 1, meaning an instruction is present at the stage input.
REQ-007 SHALL have port i_memRead input 1 and port i_memWrite input 1, meaning load or store requested.
REQ-008 SHALL have port i_memFunct input 3, meaning RISC-V funct3 access width/sign.
REQ-009 SHALL have port i_result input DATA_WIDTH, meaning the ALU result used as byte address.
REQ-010 SHALL have port i_dataB input DATA_WIDTH, meaning the store data (rs2).
REQ-011 SHALL have ports o_busReq output 1, o_busWrite output 1, o_busAddr output ADDR_WIDTH, o_busByteEnable output 4, o_busWrData output DATA_WIDTH, meaning the data-memory request.
REQ-012 SHALL have ports i_busAck input 1 and i_busRdData input DATA_WIDTH, meaning bus completion and read word.
REQ-013 SHALL have ports o_stall output 1, o_done output 1, o_readData output DATA_WIDTH, o_misaligned output 1, o_accessFault output 1, meaning the pipeline-side response.

Function
REQ-014 SHALL implement states IDLE, ACCESS, DONE.
REQ-015 SHALL, in IDLE with i_valid and exactly one of i_memRead/i_memWrite, latch address, store data, funct3 and direction.
- On the same edge, it SHALL go to ACCESS if the request is legal, else to DONE.
REQ-016 SHALL treat funct3 000/100 as byte, 001/101 as half and 010 as word; 011, 110 and 111 are illegal; store with funct3 100/101 is illegal.
REQ-017 SHALL flag misaligned on a half access with addr[0]=1 or a word access with addr[1:0]!=0.
- In that case it SHALL skip the bus, go to DONE, and pulse o_misaligned in DONE.
REQ-018 SHALL, for an illegal funct3 or simultaneous read and write, skip the bus, go to DONE, and pulse o_accessFault in DONE.
REQ-019 SHALL, in ACCESS, hold o_busReq=1 with o_busAddr={addr[ADDR_WIDTH-1:2],2'b00}, o_busByteEnable, o_busWrData and o_busWrite stable until i_busAck is sampled 1.
REQ-020 SHALL drive byte enables as: byte 0001<<addr[1:0]; half 0011<<{addr[1],0}; word 1111.
REQ-021 SHALL replicate store data: byte {4{data[7:0]}}, half {2{data[15:0]}}, word data.
REQ-022 SHALL, on ack of a load, extract the lane selected by addr and sign-extend (000, 001) or zero-extend (100, 101) into o_readData; word loads pass through unchanged.
REQ-023 SHALL leave o_readData unchanged on stores and faults; it holds the last load value.
REQ-024 SHALL count cycles in ACCESS; after TIMEOUT cycles without ack it SHALL drop o_busReq, go to DONE, and pulse o_accessFault.
REQ-025 SHALL give ack on the same cycle the counter reaches TIMEOUT priority over the timeout.
REQ-026 SHALL assert o_done for exactly one cycle in DONE and return to IDLE; no request is accepted in DONE.
REQ-027 SHALL drive o_stall = (state==ACCESS) | (state==IDLE & i_valid & (i_memRead|i_memWrite)), combinational; o_stall is 0 in DONE.
REQ-028 SHALL, when i_valid is low or there is no memory op in IDLE, keep the state in IDLE with o_done=0 and no bus activity.
REQ-029 SHALL give minimum load latency of 2 cycles from accept to o_done with ack in the first ACCESS cycle.

Reset
REQ-030 SHALL, with i_reset=0 at a clock edge, force IDLE, timeout counter 0, and o_busReq, o_done, o_misaligned, o_accessFault, o_readData and latched registers to 0, including mid-ACCESS.
REQ-031 SHALL keep o_busReq 0 after reset until a new request is accepted; an ack arriving after reset SHALL be ignored.

Verification
REQ-032 LB addr 0x103, bus word 0x80FF_1234 ack in 1st cycle -> o_busByteEnable 1000, o_done after 2 cycles, o_readData 0xFFFF_FF80.
REQ-033 SH addr 0x202 data 0x0000_ABCD -> o_busByteEnable 1100, o_busWrData 0xABCD_ABCD, o_busAddr 0x200, o_readData unchanged.
REQ-034 LW addr 0x101 -> no o_busReq, o_misaligned=1 for one cycle, o_stall high only in the accept cycle.
REQ-035 LHU addr 0x40, ack withheld -> o_accessFault after TIMEOUT=15 cycles, o_busReq deasserted; ack on cycle 15 -> normal completion instead.
REQ-036 i_reset low during ACCESS, then late ack -> IDLE, all outputs 0, ack ignored, next LW completes normally.
